// File: rtl/nibble_rx_pkg.sv
// Shared definitions for the nibble_parity_rx serial receive stage.
// State encoding, nibble width and error-counter width.
package nibble_rx_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned ERR_CNT_W = 8;

    // Receiver frame position: start bit, data bits, parity bit, stop bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage : nibble_rx_pkg

// File: rtl/nibble_parity_rx_xor4.sv
// xor4: 4-bit parity reduction used by the receive stage.
module xor4
    import nibble_rx_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    output logic                y
);

    assign y = ^a;

endmodule : xor4

// File: rtl/nibble_parity_rx.sv
// nibble_parity_rx: serial receiver for start + 4 data (LSB first) +
// parity + stop frames, sampled on an external bit-rate strobe.
// Frames are parity-checked and handed to a single-entry valid/ready
// buffer; a frame completing while the buffer is full and not being
// accepted is dropped with a one-cycle overrun pulse.
// Optional: define PARITY_ERR_CNT_EN to enable the saturating
// parity-error counter on err_cnt (otherwise err_cnt reads 0).
module nibble_parity_rx
    import nibble_rx_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [NIBBLE_W-1:0]  data,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    rx_state_t           state;
    logic [1:0]          cnt;
    logic [NIBBLE_W-1:0] shift;
    logic                pbit;

    logic                shift_par;
    logic                complete;
    logic                accept;
    logic                load;
    logic                drop;
    logic                perr;
    logic                ferr;

    // Parity of the received data bits.
    xor4 u_xor4 (
        .a (shift),
        .y (shift_par)
    );

    // Completion is the STOP-bit tick; the stop bit is the live rx sample.
    always_comb begin
        complete = tick && (state == STOP);
        accept   = valid && ready;
        load     = complete && (!valid || accept);
        drop     = complete && valid && !ready;
        perr     = shift_par ^ pbit ^ ODD_PARITY;
        ferr     = ~rx;
    end

    // Frame sequencer: advances only on tick, shifts data LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            pbit  <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shift[cnt] <= rx;
                    cnt        <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    pbit  <= rx;
                    state <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Single-entry output buffer with same-cycle replace on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data    <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            valid   <= 1'b0;
        end else if (load) begin
            data    <= shift;
            par_err <= perr;
            frm_err <= ferr;
            valid   <= 1'b1;
        end else if (accept) begin
            valid   <= 1'b0;
        end
    end

    // Overrun pulses for one cycle when a completed frame finds the buffer blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= drop;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Count delivered parity-error frames, saturating at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (load && perr && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule : nibble_parity_rx

// File: tb/tb_nibble_parity_rx.sv
// Testbench for nibble_parity_rx: directed frames, scoreboard queue of
// expected deliveries, and a monitor that checks every accepted frame.
module tb_nibble_parity_rx;
    import nibble_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx;
    logic       ready;
    logic [3:0] data;
    logic       par_err;
    logic       frm_err;
    logic       valid;
    logic       overrun;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic [3:0] d;
        logic       p;
        logic       f;
    } frame_t;

    frame_t     sb[$];
    int         checks   = 0;
    int         errors   = 0;
    int         ovr_seen = 0;
    int         ovr_exp  = 0;
    logic [7:0] cnt_exp  = '0;
    logic       v_before;

    nibble_parity_rx #(.ODD_PARITY(1'b0)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .rx      (rx),
        .data    (data),
        .par_err (par_err),
        .frm_err (frm_err),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accept pops one expected frame; overrun pulses are tallied.
    always @(negedge clk) begin
        frame_t e;
        if (reset && overrun) ovr_seen++;
        if (reset && valid && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got data=%0h with empty scoreboard", data);
            end else begin
                e = sb.pop_front();
                chk("frame_data", 32'(data), 32'(e.d));
                chk("frame_par_err", 32'(par_err), 32'(e.p));
                chk("frame_frm_err", 32'(frm_err), 32'(e.f));
            end
        end
    end

    // Called at posedge+1; presents one bit on a tick, then gap idle cycles with rx glitched.
    task automatic send_bit(input logic b, input int gap);
        rx   = b;
        tick = 1'b1;
        @(posedge clk); #1;
        if (gap > 0) begin
            tick = 1'b0;
            rx   = ~b;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Full frame; returns at posedge+1 right after the STOP tick edge.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                              input int gap, input logic rdy_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        if (rdy_stop) ready = 1'b1;
        v_before = valid;
        rx   = s;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        rx   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b1;
        idle(1);

        // Held frame with parity error, then reset mid-way through the next frame.
        send_frame(4'b1011, 1'b0, 1'b1, 1, 1'b0);
        idle(1);
        chk("held_valid", 32'(valid), 32'd1);
        chk("held_data", 32'(data), 32'hB);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_par_err", 32'(par_err), 32'd0);
        chk("midrst_frm_err", 32'(frm_err), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        tick = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        // Clean even-parity frame, ready held high: one-cycle valid.
        ready = 1'b1;
        sb.push_back('{d: 4'b1011, p: 1'b0, f: 1'b0});
        send_frame(4'b1011, 1'b1, 1'b1, 1, 1'b0);
        chk("lat_valid_before", 32'(v_before), 32'd0);
        chk("lat_valid_after", 32'(valid), 32'd1);
        chk("lat_data", 32'(data), 32'hB);
        idle(1);
        chk("lat_valid_dropped", 32'(valid), 32'd0);

        // Idle ticks with rx high, then parity-error frame.
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        sb.push_back('{d: 4'b1011, p: 1'b1, f: 1'b0});
`ifdef PARITY_ERR_CNT_EN
        cnt_exp = cnt_exp + 8'd1;
`endif
        send_frame(4'b1011, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        chk("perr_err_cnt", 32'(err_cnt), 32'(cnt_exp));

        // Framing error: stop bit 0 still delivers the frame.
        sb.push_back('{d: 4'h0, p: 1'b0, f: 1'b1});
        send_frame(4'h0, 1'b0, 1'b0, 1, 1'b0);
        idle(2);

        // Back-to-back ticks.
        sb.push_back('{d: 4'h6, p: 1'b0, f: 1'b0});
        send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // Backpressure: second frame dropped with overrun pulse.
        ready = 1'b0;
        sb.push_back('{d: 4'h5, p: 1'b0, f: 1'b0});
        send_frame(4'h5, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        chk("bp_valid", 32'(valid), 32'd1);
        send_frame(4'hA, 1'b0, 1'b1, 1, 1'b0);
        ovr_exp++;
        chk("bp_overrun_pulse", 32'(overrun), 32'd1);
        chk("bp_data_held", 32'(data), 32'h5);
        idle(1);
        chk("bp_overrun_end", 32'(overrun), 32'd0);
        chk("bp_data_stable", 32'(data), 32'h5);
        ready = 1'b1;
        idle(1);
        chk("bp_valid_dropped", 32'(valid), 32'd0);
        ready = 1'b0;
        idle(1);

        // Accept and completion on the same edge: replace, no overrun.
        sb.push_back('{d: 4'h3, p: 1'b0, f: 1'b0});
        send_frame(4'h3, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        sb.push_back('{d: 4'hC, p: 1'b0, f: 1'b0});
        send_frame(4'hC, 1'b0, 1'b1, 1, 1'b1);
        chk("sim_valid", 32'(valid), 32'd1);
        chk("sim_data", 32'(data), 32'hC);
        chk("sim_overrun", 32'(overrun), 32'd0);
        idle(1);
        chk("sim_valid_dropped", 32'(valid), 32'd0);
        ready = 1'b0;
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        chk("final_err_cnt", 32'(err_cnt), 32'(cnt_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nibble_parity_rx

// File: doc/nibble_parity_rx.md
Name: nibble_parity_rx

Overview:
- Serial receive stage feeding the 4-bit parity checker (xor4): deserialises frames of start bit, 4 data bits LSB-first, parity bit and stop bit.
- Sampling is driven by an external one-cycle bit-rate strobe.
- Each received nibble is checked against its parity bit.
- Data plus error flags are presented on a single-entry valid/ready output buffer for the downstream consumer.

Parameters:
- ODD_PARITY, 0, 0 = even parity (data XOR parity bit == 0); 1 = odd parity (== 1).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- tick  in  1  bit-period strobe, one clk wide; rx is sampled only on clk edges where tick=1.
- rx  in  1  serial line, idle high.
- data  out  4  received nibble.
- par_err  out  1  parity mismatch for the frame in data.
- frm_err  out  1  stop bit sampled 0 for the frame in data.
- valid  out  1  data/par_err/frm_err hold a frame.
- ready  in  1  consumer accepts the frame when valid && ready.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- err_cnt  out  8  saturating parity-error count (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, bit counter=0, shift reg=0, and data, par_err, frm_err, valid, overrun and err_cnt all 0. A partially received frame is discarded.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on tick=1 cycles; tick=0 holds state.
- IDLE: when tick=1 and rx=0 (start bit), go to DATA with cnt=0. When rx=1, stay in IDLE.
- DATA: shift rx into bit position cnt (LSB first) and increment cnt. After the 4th bit (cnt==3), go to PARITY.
- PARITY: capture rx as pbit and go to STOP.
- STOP, completion event:
  - Capture stop = rx.
  - Compute perr = (^shift) ^ pbit ^ ODD_PARITY.
  - Compute ferr = ~stop.
  - Go to IDLE.
  - A frame with ferr=1 is still delivered, with frm_err=1.
- Output buffer, evaluated each clk:
  - accept = valid && ready.
  - If completion and (!valid or accept): load data, par_err and frm_err; valid=1 on the next cycle.
  - Latency: valid rises on the clk edge after the STOP tick.
  - Else if completion and valid and !ready: new frame dropped, buffer unchanged, overrun=1 for exactly one cycle.
  - Else if accept: valid=0.
- Output stability: data and flags stay stable while valid=1 and not accepted.
- Same-cycle accept plus completion: the new frame replaces the old one, valid stays 1, no overrun.
- tick asserted on consecutive cycles is legal; each asserted cycle is one bit.
- rx glitches between ticks are ignored.
- No restart mid-frame: a 0 seen in STOP is a framing error, not a new start bit.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each delivered frame (loaded into the buffer) with par_err=1. It saturates at 8'hFF and is cleared only by reset. Dropped frames do not count.
- Undefined: counter logic absent; err_cnt tied to 8'h00.

Decomposition:
- Shared package nibble_rx_pkg:
  - state enum type rx_state_t {IDLE, DATA, PARITY, STOP}.
  - localparam NIBBLE_W = 4.
  - localparam ERR_CNT_W = 8.
- Sub-module: instantiate the existing xor4 for the parity reduction of the shift register. No other sub-modules.

Test Plan:
- Reset mid-frame: pull reset low during DATA, release, then send a clean frame -> all outputs 0 during reset; the next frame is received correctly.
- Even parity: send 0, bits 1,1,0,1 (nibble 4'b1011), parity 1, stop 1 with ready=1 -> data=4'b1011, par_err=0, frm_err=0, valid high 1 cycle after the STOP tick, then low after accept.
- Parity error: same frame with parity bit 0 -> par_err=1; err_cnt=1 when PARITY_ERR_CNT_EN is defined, 0 when it is not.
- Framing error: nibble 4'h0, parity 0, stop 0 -> data=4'h0, par_err=0, frm_err=1.
- Backpressure/overrun:
  - ready=0, send 4'h5 then 4'hA -> data stays 4'h5, one-cycle overrun pulse at the second STOP.
  - Raise ready -> 4'h5 accepted; valid drops.
- Simultaneous accept: ready asserted on the same cycle as the second frame's STOP tick -> data becomes the new nibble, valid remains 1, overrun=0.
